// File: rtl/switch_debouncer_ce.sv
// Multi-channel switch debouncer. Inputs are synchronized every clock; a level
// change is accepted only after par_stable_ticks consecutive agreeing tick samples.
module switch_debouncer_ce #(
    parameter int par_width        = 4,
    parameter int par_stable_ticks = 20
) (
    input  logic                 i_clk_mhz,
    input  logic                 i_rst_mhz,
    input  logic                 i_ce_div,
    input  logic [par_width-1:0] i_sw,
    output logic [par_width-1:0] o_sw_deb,
    output logic [par_width-1:0] o_sw_rise,
    output logic [par_width-1:0] o_sw_fall
);

    localparam int CNT_W = $clog2(par_stable_ticks + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(par_stable_ticks - 1);

    typedef enum logic [1:0] {
        ST_LOW,
        ST_PEND_HIGH,
        ST_HIGH,
        ST_PEND_LOW
    } state_t;

    logic [par_width-1:0] sync1_reg;
    logic [par_width-1:0] sync2_reg;
    logic [par_width-1:0] s_sync;

    // The synchronizer free-runs so the tick only decides when a sample counts.
    always_ff @(posedge i_clk_mhz) begin
        if (i_rst_mhz) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= i_sw;
            sync2_reg <= sync1_reg;
        end
    end

    assign s_sync = sync2_reg;

    generate
        for (genvar gi = 0; gi < par_width; gi++) begin : g_chan
            state_t           state_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             deb_reg;
            logic             rise_reg;
            logic             fall_reg;

            always_ff @(posedge i_clk_mhz) begin
                if (i_rst_mhz) begin
                    state_reg <= ST_LOW;
                    cnt_reg   <= '0;
                    deb_reg   <= 1'b0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else begin
                    // Pulses default low so they last exactly one clock.
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                    if (i_ce_div) begin
                        case (state_reg)
                            ST_LOW: begin
                                if (s_sync[gi]) begin
                                    state_reg <= ST_PEND_HIGH;
                                    cnt_reg   <= CNT_ONE;
                                end
                            end
                            ST_PEND_HIGH: begin
                                if (!s_sync[gi]) begin
                                    state_reg <= ST_LOW;
                                    cnt_reg   <= '0;
                                end else if (cnt_reg == CNT_LAST) begin
                                    state_reg <= ST_HIGH;
                                    cnt_reg   <= '0;
                                    deb_reg   <= 1'b1;
                                    rise_reg  <= 1'b1;
                                end else begin
                                    cnt_reg <= cnt_reg + CNT_ONE;
                                end
                            end
                            ST_HIGH: begin
                                if (!s_sync[gi]) begin
                                    state_reg <= ST_PEND_LOW;
                                    cnt_reg   <= CNT_ONE;
                                end
                            end
                            ST_PEND_LOW: begin
                                if (s_sync[gi]) begin
                                    state_reg <= ST_HIGH;
                                    cnt_reg   <= '0;
                                end else if (cnt_reg == CNT_LAST) begin
                                    state_reg <= ST_LOW;
                                    cnt_reg   <= '0;
                                    deb_reg   <= 1'b0;
                                    fall_reg  <= 1'b1;
                                end else begin
                                    cnt_reg <= cnt_reg + CNT_ONE;
                                end
                            end
                            default: begin
                                state_reg <= ST_LOW;
                                cnt_reg   <= '0;
                            end
                        endcase
                    end
                end
            end

            assign o_sw_deb[gi]  = deb_reg;
            assign o_sw_rise[gi] = rise_reg;
            assign o_sw_fall[gi] = fall_reg;
        end
    endgenerate

endmodule

// File: tb/tb_switch_debouncer_ce.sv
// Directed bench for switch_debouncer_ce with 4 channels and 4-tick qualification.
module tb_switch_debouncer_ce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce;
    logic       ce_tie = 1'b0;
    logic [3:0] div_cnt = 4'd0;
    logic [3:0] sw = 4'b0000;
    logic [3:0] deb, rise, fall;

    logic [3:0] deb_model = 4'b0000;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    // Tick every 10 clocks unless tied high.
    always @(posedge clk) div_cnt <= (div_cnt == 4'd9) ? 4'd0 : div_cnt + 4'd1;
    assign ce = ce_tie | (div_cnt == 4'd9);

    switch_debouncer_ce #(
        .par_width       (4),
        .par_stable_ticks(4)
    ) dut (
        .i_clk_mhz(clk),
        .i_rst_mhz(rst),
        .i_ce_div (ce),
        .i_sw     (sw),
        .o_sw_deb (deb),
        .o_sw_rise(rise),
        .o_sw_fall(fall)
    );

    // Called at a negedge right after an input change; counts ticks that can see
    // the new level (third posedge onward) and expects commit on the n-th one.
    task automatic run_phase(input int n_ticks, input logic [3:0] acc_mask,
                             input logic lvl, input int post, input string nm);
        int         edges = 0;
        int         good = 0;
        int         after = 0;
        logic       ce_now;
        logic [3:0] exp_rise, exp_fall;
        while (1) begin
            ce_now = ce;
            @(negedge clk);
            edges++;
            exp_rise = 4'b0000;
            exp_fall = 4'b0000;
            if (ce_now && edges >= 3 && good < n_ticks) begin
                good++;
                if (good == n_ticks && acc_mask != 4'b0000) begin
                    if (lvl) begin
                        exp_rise  = acc_mask;
                        deb_model = deb_model | acc_mask;
                    end else begin
                        exp_fall  = acc_mask;
                        deb_model = deb_model & ~acc_mask;
                    end
                end
            end
            total++;
            if (deb !== deb_model) begin
                bad++;
                $display("FAIL %s_deb edge=%0d got=%b want=%b", nm, edges, deb, deb_model);
            end
            total++;
            if (rise !== exp_rise) begin
                bad++;
                $display("FAIL %s_rise edge=%0d got=%b want=%b", nm, edges, rise, exp_rise);
            end
            total++;
            if (fall !== exp_fall) begin
                bad++;
                $display("FAIL %s_fall edge=%0d got=%b want=%b", nm, edges, fall, exp_fall);
            end
            if (good == n_ticks) begin
                if (after == post) break;
                after++;
            end
            if (edges > 300) begin
                total++;
                bad++;
                $display("FAIL %s_timeout got=%0d ticks want=%0d", nm, good, n_ticks);
                break;
            end
        end
        $display("%s: phase of %0d ticks over %0d clocks", nm, n_ticks, edges);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sw  = 4'b0000;
        repeat (3) @(negedge clk);
        total++;
        if ({deb, rise, fall} !== 12'h000) begin
            bad++;
            $display("FAIL reset_state got=%h want=000", {deb, rise, fall});
        end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            total++;
            if ({deb, rise, fall} !== 12'h000) begin
                bad++;
                $display("FAIL idle cycle=%0d got=%h want=000", i, {deb, rise, fall});
            end
        end
        deb_model = 4'b0000;
        $display("test_reset: 100 idle clocks");
    endtask

    task automatic test_clean_rise();
        sw = 4'b0001;
        run_phase(4, 4'b0001, 1'b1, 3, "rise0");
    endtask

    task automatic test_bounce();
        sw = 4'b0011;
        run_phase(3, 4'b0000, 1'b1, 0, "bounce_hi");
        sw = 4'b0001;
        run_phase(1, 4'b0000, 1'b0, 0, "bounce_lo");
        sw = 4'b0011;
        run_phase(4, 4'b0010, 1'b1, 3, "bounce_final");
    endtask

    task automatic test_clean_fall();
        sw = 4'b0010;
        run_phase(4, 4'b0001, 1'b0, 3, "fall0");
    endtask

    task automatic test_reset_pending();
        sw = 4'b0100;
        run_phase(3, 4'b0000, 1'b1, 0, "pend2");
        rst = 1'b1;
        deb_model = 4'b0000;
        // Held long enough to overlap a tick, which must be ignored.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++;
            if ({deb, rise, fall} !== 12'h000) begin
                bad++;
                $display("FAIL mid_reset cycle=%0d got=%h want=000", i, {deb, rise, fall});
            end
        end
        rst = 1'b0;
        run_phase(4, 4'b0100, 1'b1, 3, "post_reset2");
    endtask

    task automatic test_simultaneous();
        rst = 1'b1;
        sw  = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        deb_model = 4'b0000;
        ce_tie = 1'b1;
        repeat (3) @(negedge clk);
        sw = 4'b1111;
        run_phase(4, 4'b1111, 1'b1, 3, "simul_rise");
        sw = 4'b0000;
        run_phase(4, 4'b1111, 1'b0, 3, "simul_fall");
        ce_tie = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_bounce();
        test_clean_fall();
        test_reset_pending();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
